// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad reader: debounce states, sweep classification,
// status-word field positions and write-control bits.
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_KEYS = 16;

    localparam int DAT_VALID    = 31;
    localparam int DAT_COUNT_HI = 10;
    localparam int DAT_COUNT_LO = 8;
    localparam int DAT_OVF      = 4;
    localparam int DAT_CODE_HI  = 3;
    localparam int DAT_CODE_LO  = 0;

    localparam int CTL_FLUSH   = 0;
    localparam int CTL_CLR_OVF = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        SW_NONE  = 2'd0,
        SW_ONE   = 2'd1,
        SW_MULTI = 2'd2
    } sweep_res_t;

    function automatic sweep_res_t classify_sweep(input logic [NUM_KEYS-1:0] img);
        int n;
        n = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n += int'(img[i]);
        end
        if (n == 0) return SW_NONE;
        if (n == 1) return SW_ONE;
        return SW_MULTI;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] img);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (img[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] sat_count(input int unsigned n);
        return (n > 7) ? 3'd7 : n[2:0];
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Keycode queue: push/pop/flush, occupancy, full/empty and a sticky overflow flag.
module keypad_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic                   i_clr_ovf,
    input  logic [W-1:0]           i_din,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_drop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_ovf   = r_ovf;
    assign o_head  = r_mem[r_rd_ptr];

    // A flush wins over everything in the same cycle; a full queue still
    // accepts a push when a pop frees the head at the same edge.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign w_drop    = i_push && !i_flush && o_full && !w_do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ovf <= 1'b0;
        else if (w_drop)    r_ovf <= 1'b1;
        else if (i_clr_ovf) r_ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/keypad_dev.sv
// 4x4 matrix keypad reader: column scan, row synchronizer, sweep debounce and a
// bus-readable keycode queue. Define KEYPAD_AUTOREPEAT_EN to re-queue held keys.
module keypad_dev #(
    parameter int SCAN_DIV        = 15,
    parameter int DEBOUNCE_SWEEPS = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_SWEEPS   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic [3:0]  COL,
    input  logic [3:0]  ROW
);
    import keypad_pkg::*;

    localparam int CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_SWEEPS);

    logic [SCAN_DIV-1:0] r_div;
    logic [1:0]          r_col;
    logic [3:0]          r_col_n;
    logic [3:0]          r_row_s1;
    logic [3:0]          r_row_s2;
    logic [15:0]         r_image;
    logic [15:0]         w_image_next;
    logic                w_col_end;
    logic                w_sweep_end;

    assign w_col_end   = &r_div;
    assign w_sweep_end = w_col_end && (r_col == 2'd3);
    assign COL         = r_col_n;

    // Image bit row*4+col takes the current column's synchronized rows.
    for (genvar gi = 0; gi < 16; gi++) begin : g_image
        assign w_image_next[gi] = (r_col == 2'(gi % 4)) ? ~r_row_s2[gi / 4] : r_image[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= ROW;
            r_row_s2 <= r_row_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
            r_image <= '0;
        end else begin
            r_div <= r_div + 1'b1;
            if (w_col_end) begin
                r_col   <= r_col + 1'b1;
                r_col_n <= {r_col_n[2:0], r_col_n[3]};
                r_image <= w_image_next;
            end
        end
    end

    sweep_res_t       w_res;
    logic [KEY_W-1:0] w_code;
    logic             w_present;
    kp_state_t        r_state;
    logic [KEY_W-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rel;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_rel_inc;
    logic             r_push;
    logic             w_rpt_fire;

    assign w_res     = classify_sweep(w_image_next);
    assign w_code    = key_index(w_image_next);
    assign w_present = (w_res == SW_MULTI) || ((w_res == SW_ONE) && (w_code == r_cand));
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_rel_inc = r_rel + 1'b1;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_SWEEPS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SWEEPS - 1);

    logic [RPT_W-1:0] r_rpt;

    // Held outside HELD, so every entry into HELD starts a fresh interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rpt <= '0;
        end else if (r_state != ST_HELD) begin
            r_rpt <= '0;
        end else if (w_sweep_end && w_present) begin
            r_rpt <= (r_rpt == RPT_LAST) ? '0 : r_rpt + 1'b1;
        end
    end

    assign w_rpt_fire = (r_rpt == RPT_LAST);
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
            r_rel   <= '0;
            r_push  <= 1'b0;
        end else begin
            r_push <= 1'b0;
            if (w_sweep_end) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_res == SW_ONE) begin
                            r_cand <= w_code;
                            if (DEBOUNCE_SWEEPS == 1) begin
                                r_push  <= 1'b1;
                                r_rel   <= '0;
                                r_state <= ST_HELD;
                            end else begin
                                r_cnt   <= CNT_W'(1);
                                r_state <= ST_CONFIRM;
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if ((w_res == SW_ONE) && (w_code == r_cand)) begin
                            if (w_cnt_inc == DEB_LIMIT) begin
                                r_push  <= 1'b1;
                                r_cnt   <= '0;
                                r_rel   <= '0;
                                r_state <= ST_HELD;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (w_present) begin
                            r_rel <= '0;
                            if (w_rpt_fire) r_push <= 1'b1;
                        end else if (DEBOUNCE_SWEEPS == 1) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_rel   <= CNT_W'(1);
                            r_state <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (w_present) begin
                            r_rel   <= '0;
                            r_state <= ST_HELD;
                        end else if (w_rel_inc == DEB_LIMIT) begin
                            r_rel   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_rel <= w_rel_inc;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    logic             r_ack;
    logic [31:0]      r_dat_o;
    logic [31:0]      w_rd_word;
    logic             w_accept;
    logic             w_rd;
    logic             w_wr;
    logic [KEY_W-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf;

    // ACK itself blocks the next accept, forcing a one-cycle gap under held STB.
    assign w_accept = STB && !r_ack;
    assign w_rd     = w_accept && !WE;
    assign w_wr     = w_accept && WE;
    assign ACK      = r_ack;
    assign DAT_O    = r_dat_o;

    keypad_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (r_push),
        .i_pop     (w_rd),
        .i_flush   (w_wr && DAT_I[CTL_FLUSH]),
        .i_clr_ovf (w_wr && DAT_I[CTL_CLR_OVF]),
        .i_din     (r_cand),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ovf     (w_ovf)
    );

    always_comb begin
        w_rd_word                            = '0;
        w_rd_word[DAT_VALID]                 = !w_empty;
        w_rd_word[DAT_COUNT_HI:DAT_COUNT_LO] = sat_count(32'(w_count));
        w_rd_word[DAT_OVF]                   = w_ovf;
        w_rd_word[DAT_CODE_HI:DAT_CODE_LO]   = w_empty ? '0 : w_head;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) r_dat_o <= WE ? 32'd0 : w_rd_word;
        end
    end

endmodule

// File: doc/keypad_dev.md
Name: keypad_dev

Overview:
- Bus-attached 4x4 matrix keypad reader: the input-side counterpart of the scanned seven-segment output device.
- Drives keypad columns one at a time and samples the rows.
- Debounces single-key presses and queues keycodes in a small FIFO.
- The CPU reads keycodes over the same STB/WE/ACK slave handshake used by the display device.

Parameters:
- SCAN_DIV, 15: each column is driven for 2^SCAN_DIV clocks; one sweep = 4 columns.
- DEBOUNCE_SWEEPS, 4: consecutive identical sweeps needed to accept a press or a release (>=1).
- FIFO_DEPTH, 4: keycode queue entries (power of 2, >=2).
- REPEAT_SWEEPS, 64: auto-repeat interval in sweeps (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- STB  in  1  bus strobe, held by the initiator until ACK
- WE  in  1  1 = write, 0 = read
- DAT_I  in  32  write data
- DAT_O  out  32  read data, valid while ACK=1
- ACK  out  1  single-cycle acknowledge
- COL  out  4  column drive, one-hot active-low
- ROW  in  4  row sense, active-low (pulled up), asynchronous to clk

Behaviour:
- Reset values (reset=0, applied immediately): COL=4'b1110, ACK=0, DAT_O=0, FIFO empty, overflow=0, FSM=IDLE, all counters 0.
- Scan:
  - A free-running divider advances the column index every 2^SCAN_DIV clocks.
  - COL rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - ROW passes through a 2-flop synchronizer.
  - The synchronized ROW is sampled on the last clock of each column period, into a 16-bit sweep image: bit = row*4+col, 1 = pressed.
- Sweep result, evaluated when column 3's sample completes:
  - NONE: 0 bits set.
  - ONE(code): exactly 1 bit set; code = 4-bit index.
  - MULTI: 2 or more bits set.
- Debounce FSM (transitions occur only at sweep ends):
  - IDLE: ONE(c) -> CONFIRM; cand=c, cnt=1. Otherwise stay.
  - CONFIRM:
    - ONE(cand): cnt+1. When cnt reaches DEBOUNCE_SWEEPS, push cand and go to HELD.
    - NONE, MULTI, or ONE(other): -> IDLE.
    - With DEBOUNCE_SWEEPS=1, IDLE pushes directly and goes to HELD.
  - HELD:
    - ONE(cand) or MULTI: stay; release counter = 0.
    - NONE or ONE(other): -> RELEASE; rel=1.
  - RELEASE:
    - NONE or ONE(other): rel+1. When rel reaches DEBOUNCE_SWEEPS -> IDLE.
    - ONE(cand) or MULTI: -> HELD.
  - Exactly one push per accepted press.
- FIFO:
  - Push when full: entry dropped, overflow sets (sticky).
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Pop when empty: no-op.
- Bus:
  - A cycle with STB=1 and ACK=0 is accepted.
  - ACK=1 on the next clock for exactly one cycle, then 0 for at least one cycle, even if STB stays high.
  - DAT_O is registered at the accept edge and holds until the next accept.
- Read (WE=0):
  - DAT_O[31] = nonempty.
  - DAT_O[10:8] = occupancy (0..FIFO_DEPTH, saturates at 7).
  - DAT_O[4] = overflow.
  - DAT_O[3:0] = head code (0 if empty).
  - Other bits are 0.
  - Pops the head if nonempty; the pop happens at the accept edge.
- Write (WE=1):
  - DAT_I[0]=1 flushes the FIFO.
  - DAT_I[1]=1 clears overflow.
  - DAT_O = 0.
  - A push colliding with a flush is discarded.
- Reset mid-sweep or mid-transaction: everything returns to reset values; a pending ACK is dropped.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - While in HELD, a repeat counter counts sweeps.
  - Every REPEAT_SWEEPS sweeps in HELD, cand is pushed again.
  - The counter resets on entering HELD.
- Undefined: no repeat logic; exactly one push per press; REPEAT_SWEEPS is unused.

Decomposition:
- Package keypad_pkg:
  - FSM state encoding (IDLE, CONFIRM, HELD, RELEASE).
  - Keycode width (4).
  - DAT_O field positions (VALID=31, COUNT=10:8, OVF=4, CODE=3:0).
  - Write-control bit positions (FLUSH=0, CLR_OVF=1).
- Sub-module keypad_fifo: synchronous FIFO with push/pop/flush, count, full/empty, and overflow flag.
- Scan, synchronizer, debounce FSM and bus logic stay in keypad_dev.

Test Plan (SCAN_DIV=2, DEBOUNCE_SWEEPS=2, FIFO_DEPTH=4; 1 sweep = 16 clocks):
- Reset and scan: deassert reset, ROW=4'hF -> COL steps 1110, 1101, 1011, 0111 every 4 clocks; a read returns DAT_O=0 and ACK high for exactly 1 cycle.
- Press key 6 (row 1, col 2) held for 5 sweeps, then released -> exactly one push. First read = 32'h8000_0106; next read = 32'h0000_0000.
- Bounce: key 6 present for 1 sweep, absent, then present for 1 sweep -> nothing queued. Two keys (codes 1 and 5) held together from IDLE -> nothing queued.
- Overflow: 5 distinct debounced presses (codes 0,1,2,3,4) with no reads -> read = 32'h8000_0410. Four reads return codes 0..3; the fifth read returns 32'h0000_0010.
- Flush: 2 queued keys, write DAT_I=32'h3 -> next read = 32'h0. Reset asserted mid-CONFIRM -> no push after release of reset.
- KEYPAD_AUTOREPEAT_EN with REPEAT_SWEEPS=3: hold key 9 for 2+7 sweeps -> 3 pushes of code 9 (initial + 2 repeats); read shows count 3.
